// File: rtl/fetch_pc_unit_if.sv
// Bus between the fetch PC unit and the rest of the pipeline.
// Handshake: pc_src, stall and imem_ready are all sampled at the rising clock
// edge. imem_ready=1 means instr_in is valid for the current pc_out. stall=1
// means decode cannot accept a new instruction this cycle. pc_src=1 asks for a
// redirect to next_pc_in. pc_out and the if_id_* outputs change only on a
// rising edge or an asynchronous reset. flush_active and state_out follow the
// FSM state.
interface fetch_pc_unit_if;
    logic [15:0] next_pc_in;
    logic [15:0] instr_in;
    logic        pc_src;
    logic        stall;
    logic        imem_ready;
    logic [15:0] pc_out;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_instr;
    logic        if_id_valid;
    logic        flush_active;
    logic [1:0]  state_out;

    // The PC unit owns the PC and the IF/ID latch.
    modport master (
        input  next_pc_in, instr_in, pc_src, stall, imem_ready,
        output pc_out, if_id_pc, if_id_instr, if_id_valid, flush_active, state_out
    );

    // The pipeline side: the fetch, hazard and memory stages.
    modport slave (
        output next_pc_in, instr_in, pc_src, stall, imem_ready,
        input  pc_out, if_id_pc, if_id_instr, if_id_valid, flush_active, state_out
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and IF/ID pipeline latch. Handles stalls, instruction
// memory wait states and branch redirects. After a redirect, a flush window
// squashes wrong-path instructions that are already downstream.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          FLUSH_SLOTS = 2,
    parameter int          CNT_W       = 2
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    // The counter starts one below the slot count. The FLUSH state therefore
    // lasts exactly FLUSH_SLOTS cycles, counting the cycle in which it reaches zero.
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_SLOTS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       if_id_pc_q, if_id_pc_d;
    logic [15:0]       if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;

    logic              redirect;
    logic              advance;
    logic              bubble;

    // Redirects are ignored during FLUSH, so the wrong-path branches being squashed cannot retrigger a flush.
    assign redirect = bus.pc_src && (state_q != ST_FLUSH);
    assign advance  = !bus.stall && bus.imem_ready;
    assign bubble   = !bus.stall && !bus.imem_ready;

    // Next-state and datapath: redirect > stall > memory wait > advance
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        if (redirect) begin
            // The pending fetch is abandoned. IF/ID keeps its old contents and is marked as a bubble.
            pc_d          = bus.next_pc_in;
            if_id_valid_d = 1'b0;
            state_d       = ST_FLUSH;
            cnt_d         = FLUSH_INIT;
        end else begin
            case (state_q)
                ST_RUN, ST_WAIT_MEM, ST_FLUSH: begin
                    if (advance) begin
                        pc_d          = bus.next_pc_in;
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = bus.instr_in;
                        if_id_valid_d = 1'b1;
                    end else if (bubble) begin
                        if_id_valid_d = 1'b0;
                    end

                    if (state_q == ST_FLUSH) begin
                        // The flush window counts down whether or not the pipe is stalled.
                        if (cnt_q == '0) begin
                            state_d = bus.imem_ready ? ST_RUN : ST_WAIT_MEM;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else if (advance) begin
                        state_d = ST_RUN;
                    end else if (bubble) begin
                        state_d = ST_WAIT_MEM;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to RUN and drop the latched instruction.
                    state_d       = ST_RUN;
                    if_id_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and pipeline registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 16'h0000;
            if_id_instr_q <= 16'h0000;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.if_id_pc     = if_id_pc_q;
    assign bus.if_id_instr  = if_id_instr_q;
    assign bus.if_id_valid  = if_id_valid_q;
    assign bus.flush_active = (state_q == ST_FLUSH);
    assign bus.state_out    = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a table of directed vectors, a mid-flush reset,
// PC wrap, and a random stall/wait phase.
module tb_fetch_pc_unit;

    localparam int W = 52;   // {pc, if_id_pc, if_id_instr, valid, flush, state}

    logic clk;
    logic rst;
    fetch_pc_unit_if bus_if();

    fetch_pc_unit #(
        .RESET_PC    (16'h0000),
        .FLUSH_SLOTS (2),
        .CNT_W       (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  next_pc;
        logic [15:0]  instr;
        logic         pc_src;
        logic         stall;
        logic         ready;
        logic [W-1:0] exp;
    } vec_t;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[21];

    // Random-phase reference state
    logic [15:0] m_pc, m_ifpc, m_instr;
    logic        m_v;
    logic [1:0]  m_st;

    function automatic logic [W-1:0] pack(input logic [15:0] pc, input logic [15:0] ifpc,
                                          input logic [15:0] ifin, input logic v,
                                          input logic fl, input logic [1:0] st);
        return {pc, ifpc, ifin, v, fl, st};
    endfunction

    function automatic vec_t mk(input logic [15:0] nxt, input logic [15:0] ins, input logic src,
                                input logic stl, input logic rdy, input logic [15:0] pc,
                                input logic [15:0] ifpc, input logic [15:0] ifin, input logic v,
                                input logic fl, input logic [1:0] st);
        vec_t r;
        r.next_pc = nxt; r.instr = ins; r.pc_src = src; r.stall = stl; r.ready = rdy;
        r.exp = pack(pc, ifpc, ifin, v, fl, st);
        return r;
    endfunction

    // Scoreboard: pop the oldest expectation and compare it with the DUT outputs
    task automatic check_out(input string name);
        logic [W-1:0] e, a;
        e = exp_q.pop_front();
        a = {bus_if.pc_out, bus_if.if_id_pc, bus_if.if_id_instr,
             bus_if.if_id_valid, bus_if.flush_active, bus_if.state_out};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got pc=%h ifpc=%h ifin=%h v=%b fl=%b st=%0d, want pc=%h ifpc=%h ifin=%h v=%b fl=%b st=%0d",
                     name, a[51:36], a[35:20], a[19:4], a[3], a[2], a[1:0],
                     e[51:36], e[35:20], e[19:4], e[3], e[2], e[1:0]);
        end
    endtask

    // Driver: drive one cycle of inputs, queue the expectation, and check it just after the edge
    task automatic drive(input logic [15:0] nxt, input logic [15:0] ins, input logic src,
                         input logic stl, input logic rdy, input logic [W-1:0] exp, input string name);
        bus_if.next_pc_in = nxt;
        bus_if.instr_in   = ins;
        bus_if.pc_src     = src;
        bus_if.stall      = stl;
        bus_if.imem_ready = rdy;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        //            next     instr    src  stl  rdy  pc       ifpc     ifin     v    fl   st
        tbl[0]  = mk(16'h0002, 16'hB000, 0, 0, 1, 16'h0002, 16'h0000, 16'hB000, 1, 0, 0);
        tbl[1]  = mk(16'h0004, 16'hB002, 0, 0, 1, 16'h0004, 16'h0002, 16'hB002, 1, 0, 0);
        tbl[2]  = mk(16'h0006, 16'hB004, 0, 0, 1, 16'h0006, 16'h0004, 16'hB004, 1, 0, 0);
        tbl[3]  = mk(16'h0008, 16'hB006, 0, 1, 1, 16'h0006, 16'h0004, 16'hB004, 1, 0, 0);
        tbl[4]  = mk(16'h0008, 16'hB006, 0, 1, 1, 16'h0006, 16'h0004, 16'hB004, 1, 0, 0);
        tbl[5]  = mk(16'h0008, 16'hB006, 0, 0, 1, 16'h0008, 16'h0006, 16'hB006, 1, 0, 0);
        tbl[6]  = mk(16'h000A, 16'hB008, 0, 0, 1, 16'h000A, 16'h0008, 16'hB008, 1, 0, 0);
        tbl[7]  = mk(16'h000C, 16'hB00A, 0, 0, 1, 16'h000C, 16'h000A, 16'hB00A, 1, 0, 0);
        tbl[8]  = mk(16'h000E, 16'hB00C, 0, 0, 1, 16'h000E, 16'h000C, 16'hB00C, 1, 0, 0);
        tbl[9]  = mk(16'h0010, 16'hB00E, 0, 0, 1, 16'h0010, 16'h000E, 16'hB00E, 1, 0, 0);
        tbl[10] = mk(16'h0012, 16'hDEAD, 0, 0, 0, 16'h0010, 16'h000E, 16'hB00E, 0, 0, 1);
        tbl[11] = mk(16'h0012, 16'hDEAD, 0, 0, 0, 16'h0010, 16'h000E, 16'hB00E, 0, 0, 1);
        tbl[12] = mk(16'h0012, 16'hDEAD, 0, 0, 0, 16'h0010, 16'h000E, 16'hB00E, 0, 0, 1);
        tbl[13] = mk(16'h0012, 16'hB010, 0, 0, 1, 16'h0012, 16'h0010, 16'hB010, 1, 0, 0);
        tbl[14] = mk(16'h0040, 16'hB012, 1, 0, 1, 16'h0040, 16'h0010, 16'hB010, 0, 1, 2);
        tbl[15] = mk(16'h0042, 16'hB040, 1, 0, 1, 16'h0042, 16'h0040, 16'hB040, 1, 1, 2);
        tbl[16] = mk(16'h0044, 16'hB042, 0, 0, 1, 16'h0044, 16'h0042, 16'hB042, 1, 0, 0);
        tbl[17] = mk(16'h0100, 16'hB044, 1, 1, 1, 16'h0100, 16'h0042, 16'hB042, 0, 1, 2);
        tbl[18] = mk(16'h0102, 16'hB100, 0, 1, 1, 16'h0100, 16'h0042, 16'hB042, 0, 1, 2);
        tbl[19] = mk(16'h0102, 16'hDEAD, 0, 0, 0, 16'h0100, 16'h0042, 16'hB042, 0, 0, 1);
        tbl[20] = mk(16'h0200, 16'hDEAD, 1, 0, 0, 16'h0200, 16'h0042, 16'hB042, 0, 1, 2);

        // Reset
        rst = 1'b1;
        bus_if.next_pc_in = '0; bus_if.instr_in = '0;
        bus_if.pc_src = 1'b0; bus_if.stall = 1'b0; bus_if.imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        exp_q.push_back(pack(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0));
        check_out("reset");

        // Directed table
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].next_pc, tbl[i].instr, tbl[i].pc_src, tbl[i].stall, tbl[i].ready,
                  tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Asynchronous reset while in FLUSH, checked before any clock edge
        #1 rst = 1'b1;
        bus_if.pc_src = 1'b0;
        #1;
        exp_q.push_back(pack(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2'd0));
        check_out("rst_mid_flush");
        #1 rst = 1'b0;

        // PC wrap through next_pc_in
        drive(16'hFFFE, 16'h1111, 0, 0, 1, pack(16'hFFFE, 16'h0000, 16'h1111, 1, 0, 0), "wrap_a");
        drive(16'h0000, 16'h2222, 0, 0, 1, pack(16'h0000, 16'hFFFE, 16'h2222, 1, 0, 0), "wrap_b");

        // Random stall / memory-wait traffic
        m_pc = 16'h0000; m_ifpc = 16'hFFFE; m_instr = 16'h2222; m_v = 1'b1; m_st = 2'd0;
        for (int k = 0; k < 60; k++) begin
            logic stl, rdy;
            logic [15:0] ins, nxt;
            stl = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            ins = 16'($urandom_range(0, 16'hFFFF));
            nxt = m_pc + 16'd2;
            if (stl) begin
                // everything holds
            end else if (!rdy) begin
                m_v  = 1'b0;
                m_st = 2'd1;
            end else begin
                m_ifpc  = m_pc;
                m_instr = ins;
                m_pc    = nxt;
                m_v     = 1'b1;
                m_st    = 2'd0;
            end
            drive(nxt, ins, 1'b0, stl, rdy, pack(m_pc, m_ifpc, m_instr, m_v, 1'b0, m_st),
                  $sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
